// File: rtl/canvas_rect_filler.sv
// Rectangle-fill write engine: one command in, one clipped pixel write per cycle in raster order.
// Optional build macro RECT_OUTLINE_EN adds cmd_outline to paint only the clipped border.
module canvas_rect_filler #(
  parameter int color_palette_bit = 2,
  parameter int width             = 100,
  parameter int height            = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [9:0]                   cmd_x0,
  input  logic [9:0]                   cmd_y0,
  input  logic [9:0]                   cmd_x1,
  input  logic [9:0]                   cmd_y1,
  input  logic [color_palette_bit-1:0] cmd_color,
`ifdef RECT_OUTLINE_EN
  input  logic                         cmd_outline,
`endif
  output logic [9:0]                   writeX,
  output logic [9:0]                   writeY,
  output logic                         write_enable,
  output logic [color_palette_bit-1:0] write_color,
  output logic                         busy,
  output logic                         done
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // SETUP | normalize and clip the latched corners
  // FILL  | one pixel write per cycle
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

  localparam logic [9:0] X_LAST = 10'(width - 1);
  localparam logic [9:0] Y_LAST = 10'(height - 1);

  state_t                       r_state;
  logic [9:0]                   r_x0, r_y0, r_x1, r_y1;
  logic [9:0]                   r_xmin, r_xmax, r_ymin, r_ymax;
  logic [9:0]                   r_x, r_y;
  logic [color_palette_bit-1:0] r_color;
  logic                         r_we, r_busy, r_done;
`ifdef RECT_OUTLINE_EN
  logic                         r_outline;
`endif

  logic [9:0] w_xlo, w_xhi, w_ylo, w_yhi, w_xhi_clip, w_yhi_clip;
  logic       w_empty;
  logic       w_last_col, w_last;
  logic [9:0] w_nx, w_ny;
  logic       w_next_we;

  assign w_xlo      = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_xhi      = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_ylo      = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_yhi      = (r_y0 < r_y1) ? r_y1 : r_y0;
  assign w_xhi_clip = (w_xhi > X_LAST) ? X_LAST : w_xhi;
  assign w_yhi_clip = (w_yhi > Y_LAST) ? Y_LAST : w_yhi;
  assign w_empty    = (w_xlo > X_LAST) || (w_ylo > Y_LAST);

  assign w_last_col = (r_x == r_xmax);
  assign w_last     = w_last_col && (r_y == r_ymax);
  assign w_nx       = w_last_col ? r_xmin : r_x + 10'd1;
  assign w_ny       = w_last_col ? r_y + 10'd1 : r_y;

  // write strobe is registered, so it is decided for the pixel about to be presented
`ifdef RECT_OUTLINE_EN
  assign w_next_we = !r_outline || (w_nx == r_xmin) || (w_nx == r_xmax) ||
                     (w_ny == r_ymin) || (w_ny == r_ymax);
`else
  assign w_next_we = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_y0      <= '0;
      r_x1      <= '0;
      r_y1      <= '0;
      r_xmin    <= '0;
      r_xmax    <= '0;
      r_ymin    <= '0;
      r_ymax    <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_color   <= '0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef RECT_OUTLINE_EN
      r_outline <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_x0      <= cmd_x0;
            r_y0      <= cmd_y0;
            r_x1      <= cmd_x1;
            r_y1      <= cmd_y1;
            r_color   <= cmd_color;
`ifdef RECT_OUTLINE_EN
            r_outline <= cmd_outline;
`endif
            r_busy    <= 1'b1;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_xmin <= w_xlo;
          r_xmax <= w_xhi_clip;
          r_ymin <= w_ylo;
          r_ymax <= w_yhi_clip;
          if (w_empty) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // the first pixel always sits on the top edge, so it is always written
            r_x     <= w_xlo;
            r_y     <= w_ylo;
            r_we    <= 1'b1;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_last) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_x  <= w_nx;
            r_y  <= w_ny;
            r_we <= w_next_we;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE) && !rst;
  assign writeX       = r_x;
  assign writeY       = r_y;
  assign write_enable = r_we;
  assign write_color  = r_color;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_canvas_rect_filler.sv
// Directed bench for canvas_rect_filler with a pixel scoreboard; honours RECT_OUTLINE_EN.
module tb_canvas_rect_filler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [1:0] cmd_color = '0;
`ifdef RECT_OUTLINE_EN
  logic       cmd_outline = 1'b0;
`endif
  logic [9:0] writeX, writeY;
  logic       write_enable;
  logic [1:0] write_color;
  logic       busy, done;

  int total = 0;
  int bad   = 0;
  logic [21:0] sb_q[$];

  always #5 clk = ~clk;

  canvas_rect_filler #(.color_palette_bit(2), .width(100), .height(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x0       (cmd_x0),
    .cmd_y0       (cmd_y0),
    .cmd_x1       (cmd_x1),
    .cmd_y1       (cmd_y1),
    .cmd_color    (cmd_color),
`ifdef RECT_OUTLINE_EN
    .cmd_outline  (cmd_outline),
`endif
    .writeX       (writeX),
    .writeY       (writeY),
    .write_enable (write_enable),
    .write_color  (write_color),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: normalize, clip, raster-scan, push expected pixels
  task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                           input int c, input bit ol, output int area, output int nw);
    int xmin, xmax, ymin, ymax;
    xmin = (x0 < x1) ? x0 : x1;  xmax = (x0 < x1) ? x1 : x0;
    ymin = (y0 < y1) ? y0 : y1;  ymax = (y0 < y1) ? y1 : y0;
    if (xmax > 99) xmax = 99;
    if (ymax > 99) ymax = 99;
    area = 0;
    nw   = 0;
    if (xmin > 99 || ymin > 99) return;
    area = (xmax - xmin + 1) * (ymax - ymin + 1);
    for (int y = ymin; y <= ymax; y++)
      for (int x = xmin; x <= xmax; x++)
        if (!ol || x == xmin || x == xmax || y == ymin || y == ymax) begin
          sb_q.push_back({10'(x), 10'(y), 2'(c)});
          nw++;
        end
  endtask

  // called at a negedge; returns at a negedge
  task automatic run_cmd(input int x0, input int y0, input int x1, input int y1, input int c,
                         input bit ol, input bit hold, input int abort_after);
    int area, nw, cnt, first_k, last_k, done_k, tmo;
    logic [21:0] e;
    push_rect(x0, y0, x1, y1, c, ol, area, nw);
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
    cmd_color = 2'(c);
`ifdef RECT_OUTLINE_EN
    cmd_outline = ol;
`endif
    cmd_valid = 1'b1;
    tmo = 0;
    while (!cmd_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("accept_wait", 32'(tmo < 50), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    cnt = 0; first_k = -1; last_k = -1; done_k = -1;
    for (int k = 1; k <= area + 20; k++) begin
      @(negedge clk);
      chk("ready_low_busy", 32'(cmd_ready), 32'd0);
      if (write_enable) begin
        if (sb_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("px_x", 32'(writeX), 32'(e[21:12]));
          chk("px_y", 32'(writeY), 32'(e[11:2]));
          chk("px_color", 32'(write_color), 32'(e[1:0]));
        end
        cnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
        if (abort_after > 0 && cnt == abort_after) return;
      end
      if (done) begin
        done_k = k;
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("we_at_done", 32'(write_enable), 32'd0);
        break;
      end else chk("busy_high", 32'(busy), 32'd1);
    end
    chk("done_cycle", 32'(done_k), 32'(2 + area));
    chk("n_writes", 32'(cnt), 32'(nw));
    if (nw > 0) chk("first_write_cycle", 32'(first_k), 32'd2);
    if (!ol && nw > 0) chk("last_write_cycle", 32'(last_k), 32'(1 + area));
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    chk("ready_back", 32'(cmd_ready), 32'd1);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_writeX", 32'(writeX), 32'd0);
    chk("rst_writeY", 32'(writeY), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_color", 32'(write_color), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    run_cmd(2, 3, 4, 4, 1, 1'b0, 1'b0, 0);
    run_cmd(4, 4, 2, 3, 2, 1'b0, 1'b0, 0);
    run_cmd(98, 98, 150, 200, 1, 1'b0, 1'b0, 0);
    run_cmd(120, 5, 130, 6, 2, 1'b0, 1'b0, 0);
    run_cmd(0, 0, 0, 0, 3, 1'b0, 1'b1, 0);
    run_cmd(0, 0, 0, 0, 3, 1'b0, 1'b0, 0);
    run_cmd(99, 0, 99, 0, 2, 1'b0, 1'b0, 0);

    run_cmd(0, 0, 9, 9, 1, 1'b0, 1'b0, 20);
    #2 rst = 1'b1;
    #1;
    chk("abort_we", 32'(write_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_we", 32'(write_enable), 32'd0);
    end
    chk("abort_ready_back", 32'(cmd_ready), 32'd1);

`ifdef RECT_OUTLINE_EN
    run_cmd(1, 1, 3, 3, 2, 1'b1, 1'b0, 0);
    run_cmd(97, 97, 200, 200, 3, 1'b1, 1'b0, 0);
`endif
    run_cmd(5, 7, 6, 7, 3, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/canvas_rect_filler.md
Name: canvas_rect_filler

Overview:
Command-driven write engine that paints into the canvas pixel RAM through the canvas write port (writeX, writeY, write_enable, write_color). It accepts one rectangle-fill command over a valid/ready handshake and emits one pixel write per cycle in raster order, clipped to the canvas. It sits between user-input/drawing logic and the canvas controller, and is the sole driver of the canvas write port.

Parameters:
color_palette_bit, 2, width of a palette index (write_color width)
width, 100, canvas width in pixels; valid x range 0..width-1
height, 100, canvas height in pixels; valid y range 0..height-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command (high only in IDLE)
cmd_x0  input  10  first corner x
cmd_y0  input  10  first corner y
cmd_x1  input  10  second corner x
cmd_y1  input  10  second corner y
cmd_color  input  color_palette_bit  palette index to paint
writeX  output  10  canvas write x
writeY  output  10  canvas write y
write_enable  output  1  canvas write strobe, one pixel per cycle
write_color  output  color_palette_bit  canvas write palette index
busy  output  1  high in SETUP and FILL
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, while rst=1): state IDLE; writeX=0, writeY=0, write_enable=0, write_color=0, busy=0, done=0; cmd_ready=0 while rst is high, 1 once in IDLE after release.
- States: IDLE, SETUP, FILL, DONE.
- IDLE: cmd_ready=1. Accept on the rising edge where cmd_valid&&cmd_ready; latch all cmd_* fields; go to SETUP.
- SETUP (1 cycle): normalize so xmin=min(x0,x1), xmax=max(x0,x1); same for y. Clip: xmax=min(xmax,width-1), ymax=min(ymax,height-1). If xmin>=width or ymin>=height, the rectangle is empty: go to DONE with no writes. Otherwise load the pixel counter to (xmin,ymin) and go to FILL.
- FILL: write_enable=1 every cycle; writeX/writeY = current pixel; write_color = latched color. Advance the x counter each cycle; at xmax, wrap x to xmin and increment y. The cycle that presents (xmax,ymax) is the last FILL cycle; then go to DONE.
- DONE: write_enable=0, done=1 for exactly one cycle, busy=0; then IDLE.
- Timing: with accept at edge T, first write appears in the cycle after T+1 (2nd cycle after accept). Writes are contiguous, no gaps. N=(xmax-xmin+1)*(ymax-ymin+1) writes. done is asserted the cycle after the last write. cmd_ready returns the cycle after done.
- write_enable=0 in all states except FILL. writeX/writeY hold their last value outside FILL.
- cmd_valid while not in IDLE: ignored; cmd_ready=0. Commands are never queued.
- Arithmetic: unsigned 10-bit compares. Clipping uses parameter constants. The counter never exceeds width-1/height-1.
- Reset mid-FILL: write_enable drops asynchronously to 0, no done pulse, command discarded.

Optional Feature:
RECT_OUTLINE_EN: when defined, adds input port cmd_outline (1 bit, latched at accept). If the latched value is 1, the scan and timing are unchanged, but write_enable is asserted only on pixels with x==xmin, x==xmax, y==ymin or y==ymax. Borders use the clipped bounds. When the macro is undefined, the port is absent and every pixel in the rectangle is written.

Test Plan:
- Reset, then cmd (2,3)-(4,4) color 1 -> 6 contiguous writes (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) with write_color=1; first write 2 cycles after accept; done 1 cycle after last write; cmd_ready 1 cycle later.
- Swapped corners (4,4)-(2,3) color 2 -> same 6-write sequence as above, with color 2.
- Clipping (98,98)-(150,200) on 100x100 -> exactly 4 writes: (98,98),(99,98),(98,99),(99,99).
- Off-canvas (120,5)-(130,6) -> zero writes; done pulses 2 cycles after accept.
- Single pixel (0,0)-(0,0) color 3 with cmd_valid held high continuously -> one write, then done; second command accepted only after cmd_ready returns, not during SETUP/FILL.
- Reset asserted after 20 writes of (0,0)-(9,9) -> write_enable=0 immediately, busy=0, no done; cmd_ready=1 after release. With RECT_OUTLINE_EN, (1,1)-(3,3) outline -> 8 writes, (2,2) skipped, 9-cycle FILL.
